mem_stage_ctrl: RTL and testbench

- Consumer end of the EX/MEM pipeline register and producer of the MEM/WB pipeline register in the 5-stage RISC pipeline.
- Issues word loads and stores to data memory over a req/ready handshake.
- Stalls upstream stages while an access is outstanding.
- Registers the write-back value (ALU result or load data) into the MEM/WB register.

---
 rtl/mem_stage_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: issues word loads/stores over a req/ready handshake and fills MEM/WB.
// States: IDLE = pass-through / accept a new entry, BUSY = access outstanding.
package mem_stage_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_or_mem_val;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;
endpackage

module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_mem_t     ex_mem_i,
    output mem_wb_t     mem_wb_o,
    output logic        stall_o,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    mem_wb_t     mem_wb_q, mem_wb_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic        stall;
    logic        mem_op;
    logic        timeout_hit;

    assign mem_op      = ex_mem_i.valid & (ex_mem_i.mem_read | ex_mem_i.mem_write);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        mem_wb_d = '0;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = ex_mem_i.mem_write & ~ex_mem_i.mem_read;
                    addr_d  = {ex_mem_i.alu_result[31:2], 2'b00};
                    wdata_d = ex_mem_i.rs2;
                    cnt_d   = '0;
                end else begin
                    mem_wb_d.valid          = ex_mem_i.valid;
                    mem_wb_d.alu_or_mem_val = ex_mem_i.alu_result;
                    mem_wb_d.rd             = ex_mem_i.rd;
                    mem_wb_d.reg_write      = ex_mem_i.reg_write & ex_mem_i.valid;
                end
            end
            BUSY: begin
                // ex_mem_i is still held by upstream here, so its fields describe the outstanding op
                if (dmem_ready) begin
                    state_d                 = IDLE;
                    req_d                   = 1'b0;
                    mem_wb_d.valid          = 1'b1;
                    mem_wb_d.alu_or_mem_val = ex_mem_i.mem_to_reg ? dmem_rdata : ex_mem_i.alu_result;
                    mem_wb_d.rd             = ex_mem_i.rd;
                    mem_wb_d.reg_write      = ex_mem_i.reg_write;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mem_wb_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mem_wb_q <= mem_wb_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stall is gated by reset so an abandoned access releases upstream immediately
    assign stall_o    = stall & ~rst;
    assign mem_wb_o   = mem_wb_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl with a MEM/WB scoreboard queue.
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    mem_wb_t exp_q[$];

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_mem_i   (ex_mem),
        .mem_wb_o   (mem_wb),
        .stall_o    (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_t mk(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                                   input logic [4:0] rd, input logic mr, input logic mw,
                                   input logic rw, input logic m2r);
        ex_mem_t e;
        e.valid = v; e.alu_result = alu; e.rs2 = rs2; e.rd = rd;
        e.mem_read = mr; e.mem_write = mw; e.reg_write = rw; e.mem_to_reg = m2r;
        return e;
    endfunction

    function automatic mem_wb_t wb(input logic [31:0] val, input logic [4:0] rd, input logic rw);
        mem_wb_t w;
        w.valid = 1'b1; w.alu_or_mem_val = val; w.rd = rd; w.reg_write = rw;
        return w;
    endfunction

    // Scoreboard: every valid MEM/WB entry must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wb.valid) begin
                if (exp_q.size() == 0) begin
                    check_val("wb_unexpected", 64'(mem_wb), 64'(0));
                end else begin
                    mem_wb_t e;
                    e = exp_q.pop_front();
                    check_val("wb_entry", 64'(mem_wb), 64'(e));
                end
            end else begin
                check_val("bubble_rw", 64'(mem_wb.reg_write), 64'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        ex_mem     = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        #3;
        check_val("rst_req",    64'(dmem_req),   64'(0));
        check_val("rst_we",     64'(dmem_we),    64'(0));
        check_val("rst_addr",   64'(dmem_addr),  64'(0));
        check_val("rst_wdata",  64'(dmem_wdata), 64'(0));
        check_val("rst_err",    64'(err),        64'(0));
        check_val("rst_wb",     64'(mem_wb),     64'(0));
        check_val("rst_stall",  64'(stall),      64'(0));
        tick();
        rst = 1'b0;
        tick();

        // ALU pass-through, with a stray dmem_ready in IDLE that must be ignored
        ex_mem = mk(1, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 1, 0);
        dmem_ready = 1'b1;
        exp_q.push_back(wb(32'h0000_1234, 5'd5, 1'b1));
        #1;
        check_val("alu_stall", 64'(stall), 64'(0));
        tick();
        ex_mem = '0;
        dmem_ready = 1'b0;
        check_val("alu_req", 64'(dmem_req), 64'(0));
        tick();

        // Invalid entry flagged as load never issues
        ex_mem = mk(0, 32'h0000_0700, 32'h0, 5'd2, 1, 0, 1, 1);
        #1;
        check_val("inv_stall", 64'(stall), 64'(0));
        tick();
        check_val("inv_req", 64'(dmem_req), 64'(0));
        ex_mem = '0;
        tick();

        // Load with ready on the third BUSY cycle
        ex_mem = mk(1, 32'h0000_0103, 32'h0, 5'd7, 1, 0, 1, 1);
        #1;
        check_val("ld_stall0", 64'(stall), 64'(1));
        tick();
        check_val("ld_req",    64'(dmem_req),  64'(1));
        check_val("ld_we",     64'(dmem_we),   64'(0));
        check_val("ld_addr",   64'(dmem_addr), 64'(32'h100));
        check_val("ld_stall1", 64'(stall),     64'(1));
        tick();
        check_val("ld_stall2", 64'(stall),     64'(1));
        check_val("ld_req2",   64'(dmem_req),  64'(1));
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        exp_q.push_back(wb(32'hDEAD_BEEF, 5'd7, 1'b1));
        #1;
        check_val("ld_stall3", 64'(stall), 64'(0));
        tick();
        ex_mem = '0;
        dmem_ready = 1'b0;
        check_val("ld_req_off", 64'(dmem_req), 64'(0));
        tick();

        // Store with immediate ready
        ex_mem = mk(1, 32'h0000_0200, 32'hCAFE_F00D, 5'd3, 0, 1, 0, 0);
        exp_q.push_back(wb(32'h0000_0200, 5'd3, 1'b0));
        #1;
        check_val("st_stall0", 64'(stall), 64'(1));
        tick();
        dmem_ready = 1'b1;
        #1;
        check_val("st_req",    64'(dmem_req),   64'(1));
        check_val("st_we",     64'(dmem_we),    64'(1));
        check_val("st_wdata",  64'(dmem_wdata), 64'(32'hCAFE_F00D));
        check_val("st_addr",   64'(dmem_addr),  64'(32'h200));
        check_val("st_stall1", 64'(stall),      64'(0));
        tick();
        ex_mem = '0;
        dmem_ready = 1'b0;
        check_val("st_req_off", 64'(dmem_req), 64'(0));
        tick();

        // Back-to-back loads; the second also has mem_write set, so read must win
        ex_mem = mk(1, 32'h0000_0300, 32'h0, 5'd8, 1, 0, 1, 1);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111_1111;
        exp_q.push_back(wb(32'h1111_1111, 5'd8, 1'b1));
        tick();
        ex_mem = mk(1, 32'h0000_0407, 32'h5555_5555, 5'd9, 1, 1, 1, 1);
        dmem_ready = 1'b0;
        #1;
        check_val("b2b_gap",    64'(dmem_req), 64'(0));
        check_val("b2b_stall",  64'(stall),    64'(1));
        tick();
        check_val("b2b_req2",   64'(dmem_req),  64'(1));
        check_val("b2b_addr2",  64'(dmem_addr), 64'(32'h404));
        check_val("b2b_we2",    64'(dmem_we),   64'(0));
        dmem_ready = 1'b1;
        dmem_rdata = 32'h2222_2222;
        exp_q.push_back(wb(32'h2222_2222, 5'd9, 1'b1));
        tick();
        ex_mem = '0;
        dmem_ready = 1'b0;
        tick();

        // Timeout: ready never comes, TIMEOUT=4
        ex_mem = mk(1, 32'h0000_0500, 32'h0, 5'd10, 1, 0, 1, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("to_req%0d", i),   64'(dmem_req), 64'(1));
            check_val($sformatf("to_err%0d", i),   64'(err),      64'(0));
            check_val($sformatf("to_stall%0d", i), 64'(stall),    64'(i < 3 ? 1 : 0));
            tick();
        end
        check_val("to_req_off", 64'(dmem_req),  64'(0));
        check_val("to_err",     64'(err),       64'(1));
        check_val("to_wb",      64'(mem_wb.valid), 64'(0));
        ex_mem = mk(1, 32'h0000_0055, 32'h0, 5'd11, 0, 0, 1, 0);
        exp_q.push_back(wb(32'h0000_0055, 5'd11, 1'b1));
        tick();
        check_val("to_err_clr", 64'(err), 64'(0));
        ex_mem = '0;
        tick();

        // Async reset in the middle of a load, then the same load completes
        ex_mem = mk(1, 32'h0000_0600, 32'h0, 5'd12, 1, 0, 1, 1);
        tick();
        check_val("ar_req_pre", 64'(dmem_req), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_val("ar_req",   64'(dmem_req), 64'(0));
        check_val("ar_stall", 64'(stall),    64'(0));
        check_val("ar_wb",    64'(mem_wb),   64'(0));
        tick();
        rst = 1'b0;
        #1;
        check_val("ar_restall", 64'(stall), 64'(1));
        tick();
        check_val("ar_req2",  64'(dmem_req),  64'(1));
        check_val("ar_addr2", 64'(dmem_addr), 64'(32'h600));
        dmem_ready = 1'b1;
        dmem_rdata = 32'h6666_6666;
        exp_q.push_back(wb(32'h6666_6666, 5'd12, 1'b1));
        tick();
        ex_mem = '0;
        dmem_ready = 1'b0;
        tick();
        tick();
        check_val("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
